// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor: each stage ripples one CHUNK-bit slice and
// registers its carry into the next stage, with valid/ready handshake and full backpressure.
module pipelined_rca #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("pipelined_rca: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic              adv;
  logic [STAGES-1:0] v_r;
  logic [STAGES-1:0] c_r;
  logic [WIDTH-1:0]  a_r [STAGES];
  logic [WIDTH-1:0]  b_r [STAGES];
  logic [WIDTH-1:0]  s_r [STAGES];

  // Per-stage inputs: stage 0 sees the port operands, stage k sees stage k-1's registers.
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [STAGES-1:0] src_c;
  logic [WIDTH-1:0]  nxt_s [STAGES];
  logic [STAGES-1:0] nxt_c;
  logic [CHUNK:0]    part  [STAGES];

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  always_comb begin
    src_a[0] = a;
    src_b[0] = sub ? ~b : b;
    src_s[0] = '0;
    src_c    = '0;
    src_c[0] = sub | cin;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_a[k] = a_r[k-1];
      src_b[k] = b_r[k-1];
      src_s[k] = s_r[k-1];
      src_c[k] = c_r[k-1];
    end
    nxt_c = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      part[k]  = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
               + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
               + (CHUNK+1)'(src_c[k]);
      nxt_s[k] = src_s[k];
      nxt_s[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
      nxt_c[k] = part[k][CHUNK];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_r <= '0;
      c_r <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_r[k] <= '0;
        b_r[k] <= '0;
        s_r[k] <= '0;
      end
    end else if (adv) begin
      v_r[0] <= in_valid;
      for (int unsigned k = 1; k < STAGES; k++) begin
        v_r[k] <= v_r[k-1];
      end
      c_r <= nxt_c;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_r[k] <= src_a[k];
        b_r[k] <= src_b[k];
        s_r[k] <= nxt_s[k];
      end
    end
  end

  assign out_valid = v_r[LAST];
  assign sum       = s_r[LAST];
  assign cout      = c_r[LAST];
  // Carry into the MSB is recovered from the registered MSB operands and sum bit.
  assign ovf       = a_r[LAST][WIDTH-1] ^ b_r[LAST][WIDTH-1] ^ s_r[LAST][WIDTH-1] ^ c_r[LAST];

endmodule

// File: tb/tb_pipelined_rca.sv
// Self-checking bench for pipelined_rca (WIDTH=16, CHUNK=4) with an arithmetic reference model.
module tb_pipelined_rca;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [15:0] a, b;
  logic        cin, sub;
  logic        out_valid, out_ready;
  logic [15:0] sum;
  logic        cout, ovf;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned pushes = 0;
  int unsigned pops = 0;
  logic [17:0] q[$];
  logic        prev_stall = 1'b0;
  logic [17:0] prev_out;

  pipelined_rca #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference result {sum, cout, ovf} from integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic s);
    int ux, uy, sx, sy, ur, sr;
    logic co, ov;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      ur = ux - uy;
      sr = sx - sy;
      co = (ux >= uy);
    end else begin
      ur = ux + uy + int'(ci);
      sr = sx + sy + int'(ci);
      co = (ur > 65535);
    end
    ov = (sr > 32767) || (sr < -32768);
    return {ur[15:0], co, ov};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_result", {sum, cout, ovf}, prev_out);
      end
      if (out_valid && out_ready) begin
        check("pop_nonempty", q.size() != 0, 1);
        if (q.size() != 0) check("result", {sum, cout, ovf}, q.pop_front());
        pops++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, cin, sub));
        pushes++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {sum, cout, ovf};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat with out_ready=1; checks latency and the given expected values.
  task automatic send_check(input logic [15:0] x, input logic [15:0] y, input logic ci,
                            input logic s, input logic [15:0] esum, input logic ecout,
                            input logic eovf);
    int cnt;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = x; b = y; cin = ci; sub = s;
    cnt = 0;
    while (cnt < 20) begin
      tick();
      cnt++;
      if (cnt == 1) in_valid = 1'b0;
      if (out_valid) break;
    end
    check("latency", cnt, 4);
    check("dir_sum", sum, esum);
    check("dir_cout", cout, ecout);
    check("dir_ovf", ovf, eovf);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, cyc, p0;
    logic acc;
    logic [17:0] first;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_flags", {cout, ovf}, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    tick();

    send_check(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    send_check(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_check(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send_check(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send_check(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    send_check(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);

    // Random stream with pseudo-random backpressure.
    sent = 0; cyc = 0;
    in_valid = 1'b1;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    while (sent < 20 && cyc < 400) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) begin
        sent++;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      end
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_sent", sent, 20);
    out_ready = 1'b1;
    cyc = 0;
    while (q.size() != 0 && cyc < 20) begin tick(); cyc++; end
    check("drain_empty", q.size(), 0);
    check("push_pop_balance", pops, pushes);

    // Fill the pipe, stall for 10 cycles, then release.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      if (i == 0) first = model(a, b, cin, sub);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_first", {sum, cout, ovf}, first);
      tick();
    end
    p0 = int'(pops);
    out_ready = 1'b1;
    repeat (4) tick();
    check("release_count", int'(pops) - p0, 4);
    check("release_empty", out_valid, 0);

    // Reset with beats in flight.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_sum", sum, 0);
    check("async_rst_flags", {cout, ovf}, 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("no_stale", out_valid, 0);
      tick();
    end
    send_check(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
